ahb_blockram_if: RTL and testbench

AHB_BLOCKRAM_IF -- requirements
Module: ahb_blockram_if

---
 rtl/ahb_blockram_if.sv | 142 ++++++++++++++
 tb/tb_ahb_blockram_if.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ahb_blockram_if.sv
// ---------------------------------------------------------------------------
// ahb_blockram_if : zero-wait AHB-Lite slave front end for a dual-port block RAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module ahb_blockram_if #(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic [31:0]           HADDR,
  input  logic [1:0]            HTRANS,
  input  logic [2:0]            HSIZE,
  input  logic                  HWRITE,
  input  logic [31:0]           HWDATA,
  input  logic                  HREADY,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [31:0]           HRDATA,
  output logic [ADDR_WIDTH-1:0] addra,
  output logic [31:0]           dina,
  output logic [3:0]            wea,
  output logic [ADDR_WIDTH-1:0] addrb,
  input  logic [31:0]           doutb
);

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_ERR1 = 2'd1,
    ST_ERR2 = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
  logic [3:0]              mask_q, mask_d;
  logic                    wr_q, wr_d;
  logic                    rd_q, rd_d;
  logic                    hit_q, hit_d;
  logic [3:0]              fmask_q, fmask_d;
  logic [31:0]             fdata_q, fdata_d;

  logic [ADDR_WIDTH-1:0]   w_aword;
  logic [3:0]              w_amask;
  logic                    w_illegal;
  logic                    w_accept;
  logic [31:0]             w_merged;
  logic                    w_unused;

  assign w_aword  = HADDR[ADDR_WIDTH+1:2];
  assign w_unused = ^{HADDR[31:ADDR_WIDTH+2], HTRANS[0]};
  assign w_accept = HSEL & HTRANS[1] & HREADY & (state_q != ST_ERR1);

  always_comb begin
    w_amask   = 4'b0000;
    w_illegal = 1'b0;
    case (HSIZE)
      3'b000:  w_amask = 4'b0001 << HADDR[1:0];
      3'b001: begin
        w_amask   = HADDR[1] ? 4'b1100 : 4'b0011;
        w_illegal = HADDR[0];
      end
      3'b010: begin
        w_amask   = 4'b1111;
        w_illegal = |HADDR[1:0];
      end
      default: w_illegal = 1'b1;
    endcase
  end

  always_comb begin
    state_d = ST_OKAY;
    wr_d    = 1'b0;
    rd_d    = 1'b0;
    waddr_d = waddr_q;
    mask_d  = mask_q;
    hit_d   = 1'b0;
    fmask_d = fmask_q;
    fdata_d = fdata_q;

    case (state_q)
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_OKAY;
    endcase

    if (w_accept) begin
      if (w_illegal) begin
        state_d = ST_ERR1;
      end else begin
        wr_d    = HWRITE;
        rd_d    = ~HWRITE;
        waddr_d = w_aword;
        mask_d  = w_amask;
      end
    end

    // RAM returns pre-write data when a read address meets the pending write
    if (wr_q && w_accept && !w_illegal && !HWRITE && (w_aword == waddr_q)) begin
      hit_d   = 1'b1;
      fmask_d = mask_q;
      fdata_d = HWDATA;
    end
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q <= ST_OKAY;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      waddr_q <= '0;
      mask_q  <= 4'b0000;
      hit_q   <= 1'b0;
      fmask_q <= 4'b0000;
      fdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      waddr_q <= waddr_d;
      mask_q  <= mask_d;
      hit_q   <= hit_d;
      fmask_q <= fmask_d;
      fdata_q <= fdata_d;
    end
  end

  for (genvar b = 0; b < 4; b++) begin : g_lane
    assign w_merged[8*b +: 8] = (hit_q && fmask_q[b]) ? fdata_q[8*b +: 8] : doutb[8*b +: 8];
  end

  assign HREADYOUT = (state_q != ST_ERR1);
  assign HRESP     = (state_q != ST_OKAY);
  assign HRDATA    = rd_q ? w_merged : 32'h0;
  assign addra     = waddr_q;
  assign dina      = HWDATA;
  assign wea       = wr_q ? mask_q : 4'b0000;
  assign addrb     = w_aword;

endmodule

`default_nettype wire

// File: tb/tb_ahb_blockram_if.sv
// ---------------------------------------------------------------------------
// tb_ahb_blockram_if : directed bench with a transaction-level memory model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_ahb_blockram_if;

  localparam int AW = 4;
  localparam logic [1:0] ID = 2'b00, BZ = 2'b01, NS = 2'b10, SQ = 2'b11;
  localparam logic [2:0] SB = 3'd0, SH = 3'd1, SW = 3'd2;

  logic          HCLK = 1'b0;
  logic          HRESETn;
  logic          HSEL;
  logic [31:0]   HADDR;
  logic [1:0]    HTRANS;
  logic [2:0]    HSIZE;
  logic          HWRITE;
  logic [31:0]   HWDATA;
  logic          HREADY;
  logic          HREADYOUT;
  logic          HRESP;
  logic [31:0]   HRDATA;
  logic [AW-1:0] addra;
  logic [31:0]   dina;
  logic [3:0]    wea;
  logic [AW-1:0] addrb;
  logic [31:0]   doutb;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] ram [0:(1<<AW)-1];

  always #5 HCLK = ~HCLK;
  assign HREADY = HREADYOUT;

  ahb_blockram_if #(.ADDR_WIDTH(AW)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR),
    .HTRANS(HTRANS), .HSIZE(HSIZE), .HWRITE(HWRITE), .HWDATA(HWDATA),
    .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP), .HRDATA(HRDATA),
    .addra(addra), .dina(dina), .wea(wea), .addrb(addrb), .doutb(doutb)
  );

  // Block RAM with registered read port and old-data read-during-write
  always @(posedge HCLK) begin
    for (int b = 0; b < 4; b++)
      if (wea[b]) ram[addra][8*b +: 8] <= dina[8*b +: 8];
    doutb <= ram[addrb];
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Transaction-level model: one pending data phase, an error-response
  // counter and the memory image every completed write has produced.
  initial begin : model
    logic [31:0] ref_mem [0:(1<<AW)-1];
    bit          m_dv, m_dw;
    int          m_addr, m_err, nbytes, off, sz;
    logic [3:0]  m_mask;
    logic [31:0] exp_rd;
    bit          acc;
    for (int i = 0; i < (1<<AW); i++) ref_mem[i] = 32'h0;
    m_dv = 0; m_dw = 0; m_addr = 0; m_err = 0; m_mask = 4'h0;
    forever begin
      @(negedge HCLK);
      if (!HRESETn) begin
        chk("rst_hreadyout", {31'h0, HREADYOUT}, 32'h1);
        chk("rst_hresp", {31'h0, HRESP}, 32'h0);
        chk("rst_wea", {28'h0, wea}, 32'h0);
        chk("rst_hrdata", HRDATA, 32'h0);
        m_dv = 0; m_err = 0;
      end else begin
        chk("hreadyout", {31'h0, HREADYOUT}, {31'h0, m_err != 1});
        chk("hresp", {31'h0, HRESP}, {31'h0, m_err != 0});
        chk("wea", {28'h0, wea}, (m_dv && m_dw) ? {28'h0, m_mask} : 32'h0);
        if (m_dv && m_dw) begin
          chk("addra", 32'(addra), 32'(m_addr));
          chk("dina", dina, HWDATA);
        end
        chk("addrb", 32'(addrb), (HADDR >> 2) % (1 << AW));
        exp_rd = (m_dv && !m_dw) ? ref_mem[m_addr] : 32'h0;
        chk("hrdata", HRDATA, exp_rd);

        if (m_dv && m_dw)
          for (int b = 0; b < 4; b++)
            if (m_mask[b]) ref_mem[m_addr][8*b +: 8] = HWDATA[8*b +: 8];

        acc = HSEL && HTRANS[1] && (m_err != 1);
        m_err = (m_err == 1) ? 2 : 0;
        m_dv = 0;
        if (acc) begin
          sz = int'(HSIZE);
          off = int'(HADDR % 4);
          nbytes = 1 << ((sz > 2) ? 0 : sz);
          if (sz > 2 || (off % nbytes) != 0) begin
            m_err = 1;
          end else begin
            m_dv   = 1;
            m_dw   = HWRITE;
            m_addr = int'((HADDR >> 2) % (1 << AW));
            m_mask = 4'(((1 << nbytes) - 1) << off);
          end
        end
      end
    end
  end

  task automatic cyc(input logic sel, input logic [1:0] tr, input logic [31:0] a,
                     input logic [2:0] sz, input logic wr, input logic [31:0] wd);
    @(posedge HCLK); #1;
    HSEL = sel; HTRANS = tr; HADDR = a; HSIZE = sz; HWRITE = wr; HWDATA = wd;
  endtask

  task automatic idle(input logic [31:0] wd);
    cyc(1'b0, ID, 32'h0, SW, 1'b0, wd);
  endtask

  initial begin : stim
    logic [7:0] bv;
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = ID;
    HSIZE = SW; HWRITE = 1'b0; HWDATA = 32'h0;
    repeat (3) @(posedge HCLK);
    #1;
    chk("lit_rst_ready", {31'h0, HREADYOUT}, 32'h1);
    chk("lit_rst_resp", {31'h0, HRESP}, 32'h0);
    chk("lit_rst_wea", {28'h0, wea}, 32'h0);
    chk("lit_rst_hrdata", HRDATA, 32'h0);
    @(posedge HCLK); #1; HRESETn = 1'b1;

    // Clear the RAM with a back-to-back burst of word writes
    cyc(1, NS, 32'h0, SW, 1, 32'h0);
    for (int i = 1; i < (1<<AW); i++) cyc(1, SQ, 32'(i*4), SW, 1, 32'h0);
    idle(32'h0);

    // Word write then separate read
    cyc(1, NS, 32'h10, SW, 1, 32'h0);
    idle(32'hDEADBEEF); #1;
    chk("lit_w_wea", {28'h0, wea}, 32'hF);
    chk("lit_w_addra", 32'(addra), 32'h4);
    cyc(1, NS, 32'h10, SW, 0, 32'h0);
    idle(32'h0); #1;
    chk("lit_r_hrdata", HRDATA, 32'hDEADBEEF);
    chk("lit_r_ready", {31'h0, HREADYOUT}, 32'h1);

    // Byte write into lane 3
    cyc(1, NS, 32'h10, SW, 1, 32'h0);
    cyc(1, NS, 32'h13, SB, 1, 32'h11223344);
    idle(32'h5A5A5A5A); #1;
    chk("lit_b_wea", {28'h0, wea}, 32'h8);
    cyc(1, NS, 32'h10, SW, 0, 32'h0);
    idle(32'h0); #1;
    chk("lit_b_hrdata", HRDATA, 32'h5A223344);

    // Byte write immediately followed by read of the same word
    cyc(1, NS, 32'h11, SB, 1, 32'h0);
    cyc(1, NS, 32'h10, SW, 0, 32'h00007700);
    idle(32'h0); #1;
    chk("lit_fwdb_hrdata", HRDATA, 32'h5A227744);

    // Halfword write forwarded into a back-to-back read
    cyc(1, NS, 32'h20, SH, 1, 32'h0);
    cyc(1, SQ, 32'h20, SW, 0, 32'h1234CAFE);
    idle(32'h0); #1;
    chk("lit_fwdh_hrdata", HRDATA, 32'h0000CAFE);
    cyc(1, NS, 32'h20, SW, 0, 32'h0);
    idle(32'h0);

    // Different word must not forward
    cyc(1, NS, 32'h28, SW, 1, 32'h0);
    cyc(1, NS, 32'h2C, SW, 0, 32'h99999999);
    idle(32'h0); #1;
    chk("lit_nofwd_hrdata", HRDATA, 32'h0);

    // Misaligned word -> two-cycle ERROR; write offered during ERR1 is dropped
    cyc(1, NS, 32'h02, SW, 1, 32'h0);
    cyc(1, NS, 32'h08, SW, 1, 32'hFFFFFFFF); #1;
    chk("lit_err1_ready", {31'h0, HREADYOUT}, 32'h0);
    chk("lit_err1_resp", {31'h0, HRESP}, 32'h1);
    chk("lit_err1_wea", {28'h0, wea}, 32'h0);
    idle(32'hEEEEEEEE); #1;
    chk("lit_err2_ready", {31'h0, HREADYOUT}, 32'h1);
    chk("lit_err2_resp", {31'h0, HRESP}, 32'h1);
    chk("lit_err2_wea", {28'h0, wea}, 32'h0);
    cyc(1, NS, 32'h00, SW, 0, 32'h0); #1;
    chk("lit_post_err_resp", {31'h0, HRESP}, 32'h0);
    cyc(1, NS, 32'h08, SW, 0, 32'h0); #1;
    chk("lit_err_ram0", HRDATA, 32'h0);
    idle(32'h0); #1;
    chk("lit_err_ram8", HRDATA, 32'h0);

    // Misaligned halfword and oversized transfer
    cyc(1, NS, 32'h21, SH, 1, 32'h0);
    idle(32'h77777777);
    idle(32'h0);
    cyc(1, NS, 32'h00, 3'b011, 0, 32'h0);
    idle(32'h0);
    idle(32'h0);

    // BUSY transfer does nothing
    cyc(1, BZ, 32'h10, SW, 1, 32'h0);
    idle(32'hFFFFFFFF); #1;
    chk("lit_busy_wea", {28'h0, wea}, 32'h0);

    // Address wrap onto word 4, forwarded into read of 0x10
    cyc(1, NS, 32'h50, SW, 1, 32'h0);
    cyc(1, NS, 32'h10, SW, 0, 32'hA5A5A5A5);
    idle(32'h0); #1;
    chk("lit_wrap_hrdata", HRDATA, 32'hA5A5A5A5);

    // Back-to-back writes then back-to-back reads
    cyc(1, NS, 32'h30, SW, 1, 32'h0);
    cyc(1, SQ, 32'h34, SW, 1, 32'h30303030);
    cyc(1, NS, 32'h30, SW, 0, 32'h34343434);
    cyc(1, SQ, 32'h34, SW, 0, 32'h0); #1;
    chk("lit_b2b_rd0", HRDATA, 32'h30303030);
    idle(32'h0); #1;
    chk("lit_b2b_rd1", HRDATA, 32'h34343434);

    // Byte-lane sweep, last lane forwarded
    cyc(1, NS, 32'h3C, SB, 1, 32'h0);
    for (int i = 1; i < 4; i++) begin
      bv = 8'(8'hC0 + i - 1);
      cyc(1, NS, 32'(32'h3C + i), SB, 1, {4{bv}});
    end
    cyc(1, NS, 32'h3C, SW, 0, {4{8'hC3}});
    idle(32'h0); #1;
    chk("lit_lanes_hrdata", HRDATA, 32'hC3C2C1C0);
    cyc(1, NS, 32'h3E, SH, 1, 32'h0);
    cyc(1, NS, 32'h3C, SW, 0, 32'hBEEF0000);
    idle(32'h0); #1;
    chk("lit_upperh_hrdata", HRDATA, 32'hBEEFC1C0);

    // Reset during a write data phase
    cyc(1, NS, 32'h24, SW, 1, 32'h0);
    idle(32'h01020304);
    cyc(1, NS, 32'h24, SW, 1, 32'h0);
    idle(32'hFFFFFFFF); #1;
    chk("lit_prerst_wea", {28'h0, wea}, 32'hF);
    #1; HRESETn = 1'b0; #1;
    chk("lit_rst_wea_drop", {28'h0, wea}, 32'h0);
    chk("lit_rst_ready2", {31'h0, HREADYOUT}, 32'h1);
    chk("lit_rst_resp2", {31'h0, HRESP}, 32'h0);
    @(posedge HCLK); #1; HRESETn = 1'b1;
    cyc(1, NS, 32'h24, SW, 0, 32'h0);
    idle(32'h0); #1;
    chk("lit_rst_prior", HRDATA, 32'h01020304);

    idle(32'h0);
    idle(32'h0);
    @(posedge HCLK); #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
